icache_dm: RTL and testbench



---
 rtl/icache_dm.sv | 169 ++++++++++++++++
 tb/tb_icache_dm.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with same-cycle hit path and
// whole-line refill from a req/ack backing memory.
module icache_dm #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_addr,
  input  logic             pc_valid,
  output logic [31:0]      inst_out,
  output logic             inst_valid,
  output logic             stall,
  input  logic             flush,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned BYTE_W = 2;
  localparam int unsigned OFF_W  = $clog2(WORDS);
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned IDX_LO = BYTE_W + OFF_W;
  localparam int unsigned TAG_LO = IDX_LO + IDX_W;
  localparam int unsigned TAG_W  = 32 - TAG_LO;
  localparam int unsigned LINE_W = 32 - IDX_LO;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    FILL_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic               flush_seen_q, flush_seen_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [31:0]        data_q [LINES][WORDS];
  logic [TAG_W-1:0]   tag_q  [LINES];

  logic [IDX_W-1:0]   idx_c;
  logic [OFF_W-1:0]   off_c;
  logic [TAG_W-1:0]   tag_c;
  logic [IDX_W-1:0]   ridx_c;
  logic [TAG_W-1:0]   rtag_c;
  logic               hit_c;
  logic               data_we_c;
  logic               tag_we_c;
  logic               unused_byte_bits;

  assign idx_c  = pc_addr[IDX_LO +: IDX_W];
  assign off_c  = pc_addr[BYTE_W +: OFF_W];
  assign tag_c  = pc_addr[31:TAG_LO];
  assign ridx_c = line_q[IDX_W-1:0];
  assign rtag_c = line_q[LINE_W-1 -: TAG_W];
  assign hit_c  = valid_q[idx_c] && (tag_q[idx_c] == tag_c);

  // Byte-within-word bits are not checked for alignment.
  assign unused_byte_bits = ^pc_addr[BYTE_W-1:0];

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Next-state, lookup outputs and refill control.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    line_d       = line_q;
    cnt_d        = cnt_q;
    flush_seen_d = flush_seen_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    data_we_c    = 1'b0;
    tag_we_c     = 1'b0;
    inst_out     = '0;
    inst_valid   = 1'b0;
    stall        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pc_valid) begin
          if (hit_c) begin
            inst_out   = data_q[idx_c][off_c];
            inst_valid = 1'b1;
            if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end else begin
            stall        = 1'b1;
            line_d       = pc_addr[31:IDX_LO];
            mem_addr_d   = {pc_addr[31:IDX_LO], IDX_LO'(0)};
            mem_req_d    = 1'b1;
            cnt_d        = '0;
            flush_seen_d = 1'b0;
            if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            state_d      = REFILL;
          end
        end
      end
      REFILL: begin
        stall = 1'b1;
        if (flush) flush_seen_d = 1'b1;
        if (mem_ack) begin
          data_we_c = 1'b1;
          cnt_d     = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            tag_we_c  = 1'b1;
            mem_req_d = 1'b0;
            if (!flush_seen_q && !flush) valid_d[ridx_c] = 1'b1;
            state_d   = FILL_DONE;
          end else begin
            mem_addr_d = mem_addr_q + 32'd4;
          end
        end
      end
      FILL_DONE: begin
        stall   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush wins over any valid bit set in the same cycle.
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      line_q       <= '0;
      cnt_q        <= '0;
      flush_seen_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      line_q       <= line_d;
      cnt_q        <= cnt_d;
      flush_seen_q <= flush_seen_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Data and tag storage carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (data_we_c) data_q[ridx_c][cnt_q] <= mem_rdata;
    if (tag_we_c)  tag_q[ridx_c]         <= rtag_c;
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: refill timing, hits, conflicts, slow memory,
// flush during refill and reset during refill.
module tb_icache_dm;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      pc_addr;
  logic             pc_valid;
  logic [31:0]      inst_out;
  logic             inst_valid;
  logic             stall;
  logic             flush;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic             mem_ack;
  logic [31:0]      mem_rdata;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_delay = 0;
  logic [31:0] ack_q[$];

  icache_dm #(.LINES(16), .WORDS(4), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_addr   (pc_addr),
    .pc_valid  (pc_valid),
    .inst_out  (inst_out),
    .inst_valid(inst_valid),
    .stall     (stall),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Backing memory: word at address a is {16'hC0DE, a[15:0]}; acks after ack_delay wait cycles.
  initial begin
    int          wait_cnt;
    logic        prev_wait;
    logic [31:0] prev_addr;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    prev_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (prev_wait) check("mem_addr_stable", mem_addr, prev_addr);
        if (wait_cnt == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = {16'hC0DE, mem_addr[15:0]};
          ack_q.push_back(mem_addr);
          wait_cnt  = 0;
          prev_wait = 1'b0;
        end else begin
          mem_ack   = 1'b0;
          wait_cnt++;
          prev_wait = 1'b1;
          prev_addr = mem_addr;
        end
      end else begin
        mem_ack   = 1'b0;
        wait_cnt  = 0;
        prev_wait = 1'b0;
      end
    end
  end

  // Called just after a rising edge; holds the fetch until inst_valid, bounded by max_cyc.
  task automatic fetch(input logic [31:0] addr, input int flush_at, input int max_cyc,
                       output int stalls, output logic [31:0] word);
    int   n;
    logic got_valid;
    n        = 0;
    pc_addr  = addr;
    pc_valid = 1'b1;
    forever begin
      flush = (n == flush_at);
      #1;
      got_valid = inst_valid;
      if (got_valid || n >= max_cyc) break;
      if (!stall) check("stall_during_miss", 32'(stall), 32'd1);
      n++;
      @(posedge clk);
      #1;
    end
    flush  = 1'b0;
    word   = inst_out;
    stalls = n;
    if (!got_valid) check("fetch_timeout", 32'(got_valid), 32'd1);
    @(posedge clk);
    #1;
    pc_valid = 1'b0;
  endtask

  initial begin
    int          st;
    logic [31:0] w;
    logic [31:0] a;

    rst = 1'b1; pc_addr = '0; pc_valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_stall",      32'(stall),      32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_out",   inst_out,        32'h0);
    check("rst_mem_req",    32'(mem_req),    32'd0);
    check("rst_mem_addr",   mem_addr,        32'h0);
    check("rst_hit_cnt",    32'(hit_cnt),    32'd0);
    check("rst_miss_cnt",   32'(miss_cnt),   32'd0);
    @(posedge clk);
    #1;

    // 1: cold miss at 0x00 with ack tied high
    ack_q.delete();
    fetch(32'h00, -1, 40, st, w);
    check("t1_stall_cycles", 32'(st), 32'd6);
    check("t1_word",  w, 32'hC0DE_0000);
    check("t1_nacks", 32'(ack_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_q.size(); i++) begin
      a = ack_q[i];
      check("t1_mem_addr_seq", a, 32'(4 * i));
    end
    check("t1_miss_cnt", 32'(miss_cnt), 32'd1);
    check("t1_hit_cnt",  32'(hit_cnt),  32'd1);

    // 2: hits on the rest of the line
    for (int i = 1; i <= 4; i++) begin
      a = 32'((4 * i) % 16);
      fetch(a, -1, 40, st, w);
      check("t2_stall_cycles", 32'(st), 32'd0);
      check("t2_word", w, {16'hC0DE, a[15:0]});
    end
    check("t2_hit_cnt",  32'(hit_cnt),  32'd5);
    check("t2_miss_cnt", 32'(miss_cnt), 32'd1);

    // 3: conflict on index 0 between tag 1 and tag 0
    ack_q.delete();
    fetch(32'h100, -1, 40, st, w);
    check("t3_stall_a", 32'(st), 32'd6);
    check("t3_word_a", w, 32'hC0DE_0100);
    check("t3_first_addr", ack_q.size() > 0 ? ack_q[0] : 32'hFFFF_FFFF, 32'h100);
    check("t3_last_addr",  ack_q.size() > 0 ? ack_q[ack_q.size()-1] : 32'hFFFF_FFFF, 32'h10C);
    check("t3_miss_a", 32'(miss_cnt), 32'd2);
    fetch(32'h00, -1, 40, st, w);
    check("t3_stall_b", 32'(st), 32'd6);
    check("t3_word_b", w, 32'hC0DE_0000);
    check("t3_miss_b", 32'(miss_cnt), 32'd3);
    check("t3_hit_cnt", 32'(hit_cnt), 32'd7);

    // 4: slow memory, three wait cycles per word
    ack_delay = 3;
    ack_q.delete();
    fetch(32'h88, -1, 60, st, w);
    check("t4_stall_cycles", 32'(st), 32'd18);
    check("t4_word", w, 32'hC0DE_0088);
    check("t4_nacks", 32'(ack_q.size()), 32'd4);
    check("t4_miss_cnt", 32'(miss_cnt), 32'd4);
    ack_delay = 0;

    // 5: flush during the second refill word of 0x40
    ack_q.delete();
    fetch(32'h40, 2, 60, st, w);
    check("t5_stall_cycles", 32'(st), 32'd12);
    check("t5_word", w, 32'hC0DE_0040);
    check("t5_nacks", 32'(ack_q.size()), 32'd8);
    check("t5_miss_cnt", 32'(miss_cnt), 32'd6);
    fetch(32'h00, -1, 40, st, w);
    check("t5_old_line_stall", 32'(st), 32'd6);
    check("t5_miss_cnt_b", 32'(miss_cnt), 32'd7);
    check("t5_hit_cnt", 32'(hit_cnt), 32'd10);

    // 6: reset in the middle of a refill of 0x200
    pc_addr = 32'h200; pc_valid = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("t6_mid_refill_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; pc_valid = 1'b0;
    #1;
    check("t6_mem_req",  32'(mem_req),  32'd0);
    check("t6_stall",    32'(stall),    32'd0);
    check("t6_hit_cnt",  32'(hit_cnt),  32'd0);
    check("t6_miss_cnt", 32'(miss_cnt), 32'd0);
    @(posedge clk);
    #1;
    fetch(32'h00, -1, 40, st, w);
    check("t6_refetch_stall", 32'(st), 32'd6);
    check("t6_refetch_word", w, 32'hC0DE_0000);
    fetch(32'h80, -1, 40, st, w);
    check("t6_other_line_stall", 32'(st), 32'd6);
    check("t6_miss_after", 32'(miss_cnt), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
